multicycle_ctrl: RTL and testbench

Sequencer for the core's iterative execute operations: radix-2 restoring division/remainder and carry-less multiply (the `division` and `bit_op.bmcycle` classes produced by the decoder). It sits in the execute stage beside the single-cycle ALU. It accepts one decoded request and stalls the pipeline while it iterates. It returns one 32-bit result with a single-cycle valid pulse, and drops in-flight work on pipeline flush.

---
 rtl/multicycle_ctrl_if.sv | 24 ++
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Request/response bundle between the execute stage and the multi-cycle sequencer.
interface multicycle_ctrl_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic [6:0]      req_op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            req_ready;
   logic            stall;
   logic            resp_valid;
   logic [XLEN-1:0] result;

   modport master (
      output req_valid, req_op, rs1, rs2, flush,
      input  req_ready, stall, resp_valid, result
   );

   modport slave (
      input  req_valid, req_op, rs1, rs2, flush,
      output req_ready, stall, resp_valid, result
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Iterative div/rem and carry-less multiply sequencer for the execute stage.
// Optional feature macro: MULTICYCLE_CLMUL_EN enables the iterative clmul datapath.
module multicycle_ctrl #(
   parameter int XLEN = 32
) (
   input  logic             clock,
   input  logic             reset,
   multicycle_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef MULTICYCLE_CLMUL_EN
   localparam int OP_W = 7;
`else
   localparam int OP_W = 4;
`endif

   state_t          state, state_nxt;
   logic [OP_W-1:0] op_r;
   logic [4:0]      cnt_r;
   logic            fast_r;
   logic            neg_q_r;
   logic            neg_r_r;
   logic [XLEN-1:0] q_r;
   logic [XLEN-1:0] acc_r;
   logic [XLEN-1:0] d_r;
`ifdef MULTICYCLE_CLMUL_EN
   logic [2*XLEN-1:0] prod_r;
`endif

   logic [6:0]      sel;
   logic            accept;
   logic            is_div, is_rem, is_signed, ovf;
   logic            fast_c;
   logic [XLEN-1:0] fast_val;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN:0]   sub;
   logic            ge;
   logic [XLEN-1:0] res_fin;
`ifndef MULTICYCLE_CLMUL_EN
   logic            is_clmul;
`endif

   // Isolate the lowest set request bit so multi-hot requests resolve to one op.
   always_comb begin
      sel       = bus.req_op & (~bus.req_op + 7'd1);
      accept    = bus.req_valid & (state == IDLE) & (|bus.req_op) & ~bus.flush;
      is_div    = sel[0] | sel[1];
      is_rem    = sel[2] | sel[3];
      is_signed = sel[0] | sel[2];
      ovf       = is_signed & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2 == '1);
      mag1      = (is_signed & bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
      mag2      = (is_signed & bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
      fast_c    = (is_div | is_rem) & ((bus.rs2 == '0) | ovf);
      fast_val  = '0;
      if (bus.rs2 == '0)
         fast_val = is_div ? '1 : bus.rs1;
      else if (ovf)
         fast_val = is_div ? {1'b1, {(XLEN-1){1'b0}}} : '0;
`ifndef MULTICYCLE_CLMUL_EN
      is_clmul  = |sel[6:4];
      if (is_clmul) begin
         fast_c   = 1'b1;
         fast_val = '0;
      end
`endif
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      sub = {acc_r, q_r[XLEN-1]} - {1'b0, d_r};
      ge  = ~sub[XLEN];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = fast_c ? DONE : RUN;
         RUN: begin
            if (bus.flush)         state_nxt = IDLE;
            else if (cnt_r == '0)  state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_r    <= '0;
         cnt_r   <= '0;
         fast_r  <= 1'b0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         q_r     <= '0;
         acc_r   <= '0;
         d_r     <= '0;
`ifdef MULTICYCLE_CLMUL_EN
         prod_r  <= '0;
`endif
      end else if (state == IDLE) begin
         if (accept) begin
            op_r    <= sel[OP_W-1:0];
            fast_r  <= fast_c;
            cnt_r   <= fast_c ? 5'd0 : 5'd31;
            neg_q_r <= bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1];
            neg_r_r <= bus.rs1[XLEN-1];
            q_r     <= fast_c ? fast_val : mag1;
            acc_r   <= '0;
            d_r     <= mag2;
`ifdef MULTICYCLE_CLMUL_EN
            prod_r  <= '0;
`endif
         end
      end else if (state == RUN) begin
         if (cnt_r != '0) cnt_r <= cnt_r - 5'd1;
`ifdef MULTICYCLE_CLMUL_EN
         if (|op_r[6:4]) begin
            prod_r <= {prod_r[2*XLEN-2:0], 1'b0} ^ (q_r[XLEN-1] ? {{XLEN{1'b0}}, d_r} : '0);
            q_r    <= {q_r[XLEN-2:0], 1'b0};
         end else
`endif
         begin
            acc_r <= ge ? sub[XLEN-1:0] : {acc_r[XLEN-2:0], q_r[XLEN-1]};
            q_r   <= {q_r[XLEN-2:0], ge};
         end
      end
   end

   // Sign fix-up and product slicing happen here, from registered state only.
   always_comb begin
      res_fin = '0;
      if (fast_r)       res_fin = q_r;
      else if (op_r[0]) res_fin = neg_q_r ? -q_r : q_r;
      else if (op_r[1]) res_fin = q_r;
      else if (op_r[2]) res_fin = neg_r_r ? -acc_r : acc_r;
      else if (op_r[3]) res_fin = acc_r;
`ifdef MULTICYCLE_CLMUL_EN
      else if (op_r[4]) res_fin = prod_r[XLEN-1:0];
      else if (op_r[5]) res_fin = prod_r[2*XLEN-1:XLEN];
      else if (op_r[6]) res_fin = prod_r[2*XLEN-2:XLEN-1];
`endif
   end

   always_comb begin
      bus.req_ready  = (state == IDLE);
      bus.stall      = accept | (state == RUN);
      bus.resp_valid = (state == DONE) & ~bus.flush;
      bus.result     = bus.resp_valid ? res_fin : '0;
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed requests push expected results, a monitor checks them.
module tb_multicycle_ctrl;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   logic clock;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   multicycle_ctrl_if #(.XLEN(32)) bus ();

   multicycle_ctrl #(.XLEN(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (bus.resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=%h expected=none (cycle %0d)", bus.result, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_result"}, bus.result, e.res);
            chk({e.name, "_cycle"}, cyc, e.cyc);
            chk({e.name, "_stall_at_resp"}, {31'b0, bus.stall}, 32'd0);
         end
      end else begin
         chk("result_zero_when_idle", bus.result, 32'd0);
      end
   end

   task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
      int   n;
      exp_t e;
      @(posedge clock); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.rs1       = a;
      bus.rs2       = b;
      n             = cyc;
      @(negedge clock);
      chk({nm, "_accept_stall"}, {31'b0, bus.stall}, 32'd1);
      chk({nm, "_accept_ready"}, {31'b0, bus.req_ready}, 32'd1);
      e.res  = exp;
      e.cyc  = n + lat;
      e.name = nm;
      sb.push_back(e);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 7'h7f;
      bus.rs1       = ~a;
      bus.rs2       = ~b;
      @(negedge clock);
      chk({nm, "_stall_next"}, {31'b0, bus.stall}, (lat > 1) ? 32'd1 : 32'd0);
      for (int i = 0; i < 60; i++) begin
         @(posedge clock); #1;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_resp expected=resp", nm);
         sb.delete();
      end
      chk({nm, "_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
   endtask

   localparam logic [6:0] OP_DIVS   = 7'b0000001;
   localparam logic [6:0] OP_DIVU   = 7'b0000010;
   localparam logic [6:0] OP_REM    = 7'b0000100;
   localparam logic [6:0] OP_REMU   = 7'b0001000;
   localparam logic [6:0] OP_CLMUL  = 7'b0010000;
   localparam logic [6:0] OP_CLMULH = 7'b0100000;
   localparam logic [6:0] OP_CLMULR = 7'b1000000;

`ifdef MULTICYCLE_CLMUL_EN
   localparam int          CL_LAT = 33;
   localparam logic [31:0] CL_3X3 = 32'h5;
   localparam logic [31:0] CL_H   = 32'h4000_0000;
   localparam logic [31:0] CL_R   = 32'h8000_0000;
`else
   localparam int          CL_LAT = 1;
   localparam logic [31:0] CL_3X3 = 32'h0;
   localparam logic [31:0] CL_H   = 32'h0;
   localparam logic [31:0] CL_R   = 32'h0;
`endif

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.rs1       = '0;
      bus.rs2       = '0;
      bus.flush     = 1'b0;
      #2;
      chk("reset_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("reset_stall", {31'b0, bus.stall}, 32'd0);
      chk("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      issue(OP_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
      issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      issue(OP_DIVS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      issue(OP_DIVS, 32'd20, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 33, "div_20_m4");
      issue(OP_DIVS, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divs_by_zero");
      issue(OP_REMU, 32'h1234, 32'd0, 32'h1234, 1, "remu_by_zero");
      issue(OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divs_overflow");
      issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_overflow");
      issue(OP_CLMUL,  32'd3, 32'd3, CL_3X3, CL_LAT, "clmul_3_3");
      issue(OP_CLMULH, 32'h8000_0000, 32'h8000_0000, CL_H, CL_LAT, "clmulh_msb");
      issue(OP_CLMULR, 32'h8000_0000, 32'h8000_0000, CL_R, CL_LAT, "clmulr_msb");
      issue(7'b0000011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "multihot_divs");

      // Flush a divu at N+10: no response, back in IDLE at N+11.
      @(posedge clock); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = OP_DIVU;
      bus.rs1       = 32'd100;
      bus.rs2       = 32'd7;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1 bus.flush = 1'b1;
      @(posedge clock); #1;
      bus.flush = 1'b0;
      chk("flush_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("flush_stall", {31'b0, bus.stall}, 32'd0);
      repeat (30) @(posedge clock);
      issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_after_flush");

      // Request together with flush must be ignored.
      @(posedge clock); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = OP_DIVS;
      bus.rs1       = 32'd5;
      bus.rs2       = 32'd0;
      bus.flush     = 1'b1;
      @(negedge clock);
      chk("flush_req_stall", {31'b0, bus.stall}, 32'd0);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      chk("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);
      repeat (3) @(posedge clock);

      // Reset in the middle of RUN drops the operation.
      @(posedge clock); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = OP_DIVU;
      bus.rs1       = 32'd1000;
      bus.rs2       = 32'd3;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      repeat (5) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("midrun_reset_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("midrun_reset_stall", {31'b0, bus.stall}, 32'd0);
      chk("midrun_reset_resp", {31'b0, bus.resp_valid}, 32'd0);
      @(posedge clock); #1 reset = 1'b1;
      issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_after_reset");

      repeat (40) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
